// File: rtl/bus_arbiter_if.sv
// Command-bus handshake bundle between the requesting FSMs, the arbiter and the bus sink.
// The master side drives requests, command words and sink readiness; the slave side is the arbiter.
interface bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDRW   = 24
);
  logic [NUM_REQ-1:0]             arb_req;
  logic [NUM_REQ*(ADDRW+8)-1:0]   req_data;
  logic [NUM_REQ-1:0]             arb_grant;
  logic                           bus_ready;
  logic                           bus_valid;
  logic [ADDRW+7:0]               bus_data;

  modport master (
    output arb_req, req_data, bus_ready,
    input  arb_grant, bus_valid, bus_data
  );

  modport slave (
    input  arb_req, req_data, bus_ready,
    output arb_grant, bus_valid, bus_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one command bus among NUM_REQ control FSMs.
// One winner per ISSUE phase; the grant pulses in the cycle the sink accepts the word.
module bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDRW   = 24,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bif
);
  localparam int W = ADDRW + 8;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] pick;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] win_nxt;
  logic            found;
  logic            win_req;
  int              idx;
  logic [W-1:0]    words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = bif.req_data[g*W +: W];
  end

  // Search starts at ptr and wraps at NUM_REQ, not at 2**IDXW.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDXW'(idx);
      if (!found && bif.arb_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign win_req = bif.arb_req[win];
  assign win_nxt = (win == IDXW'(NUM_REQ - 1)) ? '0 : win + IDXW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      win   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            win   <= pick;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!win_req) begin
            state <= IDLE;
          end else if (bif.bus_ready) begin
            ptr   <= win_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid is decoded from the state flop only; a withdrawn winner still shows valid
  // for its final cycle, so the sink qualifies acceptance with the grant.
  assign bif.bus_valid = (state == ISSUE);
  assign bif.bus_data  = (state == ISSUE) ? words[win] : '0;

  always_comb begin
    bif.arb_grant = '0;
    if (state == ISSUE && win_req && bif.bus_ready) bif.arb_grant[win] = 1'b1;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random traffic,
// compared against a rotation-order reference model.
module tb_bus_arbiter;
  localparam int N     = 3;
  localparam int IW    = 2;
  localparam int ADDRW = 24;
  localparam int W     = ADDRW + 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] words [N];

  bus_arbiter_if #(.NUM_REQ(N), .ADDRW(ADDRW)) bif ();
  bus_arbiter #(.NUM_REQ(N), .ADDRW(ADDRW)) dut (.clk(clk), .rst_n(rst_n), .bif(bif));

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bif.req_data[g*W +: W] = words[g];
  end

  always #5 clk = ~clk;

  // Reference model: is a winner pending, which one, and where the rotation resumes.
  bit            m_busy;
  logic [IW-1:0] m_win;
  logic [IW-1:0] m_ptr;
  logic [N-1:0]  last_grant;
  logic [N-1:0]  gq [$];
  int            gcount;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_win  = '0;
    m_ptr  = '0;
  endtask

  function automatic logic [IW-1:0] first_req(input logic [N-1:0] req, input logic [IW-1:0] p);
    int i;
    for (int d = 0; d < N; d++) begin
      i = (int'(p) + d) % N;
      if (req[IW'(i)]) return IW'(i);
    end
    return '0;
  endfunction

  // Called at a negedge with inputs set; checks outputs, then advances one clock.
  task automatic tick(input string tag);
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    #1;
    eg = '0;
    ed = '0;
    if (m_busy) ed = words[m_win];
    if (m_busy && bif.arb_req[m_win] && bif.bus_ready) eg[m_win] = 1'b1;
    chk({tag, ".grant"}, 32'(bif.arb_grant), 32'(eg));
    chk({tag, ".valid"}, 32'(bif.bus_valid), 32'(m_busy));
    chk({tag, ".data"}, bif.bus_data, ed);
    chk({tag, ".ptr"}, 32'(dut.ptr), 32'(m_ptr));
    chk({tag, ".onehot"}, 32'($onehot0(bif.arb_grant)), 32'd1);
    last_grant = eg;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (bif.arb_req != '0) begin
        m_win  = first_req(bif.arb_req, m_ptr);
        m_busy = 1'b1;
      end
    end else if (!bif.arb_req[m_win]) begin
      m_busy = 1'b0;
    end else if (bif.bus_ready) begin
      m_ptr  = IW'((int'(m_win) + 1) % N);
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.arb_req   = '0;
    bif.bus_ready = 1'b0;
    for (int i = 0; i < N; i++) words[IW'(i)] = '0;
    model_reset();
    last_grant = '0;
    @(negedge clk);
    tick("reset");
    rst_n = 1'b1;

    // Single request
    words[0]      = 32'h12345604;
    bif.arb_req   = 3'b001;
    bif.bus_ready = 1'b1;
    tick("single.c0");
    tick("single.c1");
    chk("single.grant_seen", 32'(last_grant), 32'h1);
    bif.arb_req = '0;
    tick("single.c2");
    chk("single.ptr_after", 32'(dut.ptr), 32'd1);

    // Contention between requesters 0 and 1
    words[0]    = $urandom;
    words[1]    = $urandom;
    bif.arb_req = 3'b011;
    gq.delete();
    for (int c = 0; c < 8; c++) begin
      tick("rot");
      if (last_grant != '0) begin
        gq.push_back(last_grant);
        bif.arb_req = 3'b011 & ~last_grant;
      end else begin
        bif.arb_req = 3'b011;
      end
    end
    chk("rot.count", 32'(gq.size()), 32'd4);
    for (int i = 1; i < gq.size(); i++) chk("rot.alternate", 32'(gq[i] != gq[i-1]), 32'd1);
    bif.arb_req = '0;
    tick("rot.idle");

    // Backpressure on requester 1
    words[1]      = 32'hC0DE_5A11;
    bif.arb_req   = 3'b010;
    bif.bus_ready = 1'b0;
    gcount        = 0;
    tick("bp.c0");
    for (int c = 0; c < 5; c++) begin
      tick("bp.stall");
      if (last_grant != '0) gcount++;
    end
    bif.bus_ready = 1'b1;
    tick("bp.accept");
    if (last_grant != '0) gcount++;
    chk("bp.single_grant", 32'(gcount), 32'd1);
    chk("bp.grant_bit", 32'(last_grant), 32'h2);
    bif.arb_req = '0;
    tick("bp.idle");
    chk("wrap.ptr_before", 32'(dut.ptr), 32'd2);

    // Wrap: ptr=2, requests from 0 and 1, winner must be 0
    bif.arb_req = 3'b011;
    tick("wrap.c0");
    tick("wrap.c1");
    chk("wrap.winner", 32'(last_grant), 32'h1);
    bif.arb_req = '0;
    tick("wrap.c2");
    chk("wrap.ptr_after", 32'(dut.ptr), 32'd1);

    // Asynchronous reset in the middle of ISSUE
    words[2]      = 32'hFEED_BEEF;
    bif.arb_req   = 3'b100;
    bif.bus_ready = 1'b0;
    tick("arst.c0");
    #1;
    chk("arst.in_issue", 32'(bif.bus_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bif.bus_valid), 32'd0);
    chk("arst.data", bif.bus_data, 32'd0);
    chk("arst.grant", 32'(bif.arb_grant), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n       = 1'b1;
    bif.arb_req = '0;
    tick("arst.after");
    chk("arst.ptr", 32'(dut.ptr), 32'd0);

    // Withdraw while stalled
    bif.arb_req   = 3'b001;
    bif.bus_ready = 1'b0;
    tick("wd.c0");
    tick("wd.c1");
    bif.arb_req = '0;
    tick("wd.abort");
    chk("wd.no_grant", 32'(last_grant), 32'd0);
    tick("wd.idle");
    chk("wd.ptr", 32'(dut.ptr), 32'd0);

    // Random traffic with grants, withdrawals and backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bif.arb_req[IW'(i)] && last_grant[IW'(i)]) begin
          bif.arb_req[IW'(i)] = 1'b0;
        end else if (bif.arb_req[IW'(i)] && $urandom_range(0, 19) == 0) begin
          bif.arb_req[IW'(i)] = 1'b0;
        end else if (!bif.arb_req[IW'(i)] && $urandom_range(0, 2) == 0) begin
          words[IW'(i)]       = $urandom;
          bif.arb_req[IW'(i)] = 1'b1;
        end
      end
      bif.bus_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
